lsu_port: RTL and testbench
===========================

Name: lsu_port

Overview:
- Per-thread load/store unit. It is the consumer of the register file's rs/rt operands and the producer of its lsu_out writeback value.
- During REQUEST it latches address and data from rs/rt. It then runs a valid/ready transaction on its own port of the memory controller and holds the loaded byte until UPDATE.
- One instance per thread inside each core, alongside the ALU and the register file.

Parameters:
- DATA_BITS, 8, width of rt, lsu_out and memory data.
- ADDR_BITS, 8, width of memory address; taken from the low ADDR_BITS of rs.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  thread active in current block; gates the start of new transactions only.
- core_state  in  3  core FSM state: REQUEST=3'b011, UPDATE=3'b110.
- decoded_mem_read_enable  in  1  instruction is LDR.
- decoded_mem_write_enable  in  1  instruction is STR.
- rs  in  8  address operand.
- rt  in  DATA_BITS  store data operand.
- mem_read_valid  out  1  read request pending.
- mem_read_address  out  ADDR_BITS  read address.
- mem_read_ready  in  1  controller accepts read and returns data this cycle.
- mem_read_data  in  DATA_BITS  read data, valid when mem_read_ready=1.
- mem_write_valid  out  1  write request pending.
- mem_write_address  out  ADDR_BITS  write address.
- mem_write_data  out  DATA_BITS  write data.
- mem_write_ready  in  1  controller accepts write this cycle.
- lsu_state  out  2  IDLE=00, REQUESTING=01, DONE=11; 10 is reserved and never driven.
- lsu_out  out  DATA_BITS  last loaded value, to the register-file MEMORY mux input.
- lsu_error  out  1  sticky flag: read and write were decoded together.

Behaviour:
- Reset (reset=0, asynchronous) forces all outputs to 0 immediately:
  - lsu_state=IDLE, both valids=0, addresses=0, write data=0, lsu_out=0, lsu_error=0.
  - Any in-flight request is abandoned with no handshake completion.
- All other updates happen on the posedge of clk.
- IDLE:
  - Start condition: enable=1, core_state=REQUEST, and either decoded enable set.
  - On start with decoded_mem_read_enable=1: mem_read_valid<=1, mem_read_address<=rs[ADDR_BITS-1:0], state<=REQUESTING.
  - On start with write only: mem_write_valid<=1, mem_write_address<=rs, mem_write_data<=rt, state<=REQUESTING.
  - If both enables are set: perform the read only and set lsu_error<=1. lsu_error stays set until reset.
  - If neither enable is set: stay IDLE.
- REQUESTING:
  - The asserted valid, its address and its data stay stable until the matching ready is sampled high.
  - On a read handshake: lsu_out<=mem_read_data, mem_read_valid<=0, state<=DONE, all on the same edge.
  - On a write handshake: mem_write_valid<=0, state<=DONE.
  - Ready on the channel that is not active is ignored. Ready while valid=0 is ignored.
  - enable falling mid-transaction does not abort; the transaction completes normally.
- DONE:
  - Hold lsu_out. When core_state=UPDATE, state<=IDLE.
  - A REQUEST in the same cycle does not start a new transaction. A new start is possible only from IDLE, one cycle later at the earliest.
- Latency:
  - Valid rises one edge after the REQUEST cycle.
  - If ready is high in the first valid cycle, DONE is reached two edges after REQUEST.
  - Each additional cycle with ready low adds one cycle. There is no timeout.
- Writes never modify lsu_out, which keeps its previous load value.
- No arithmetic; addresses are truncated, never wrapped or incremented.

Decomposition:
- Shared package gpu_pkg holds:
  - core_state_t with all 8 encodings (IDLE 000 … DONE 111);
  - lsu_state_t (IDLE/REQUESTING/DONE);
  - the DATA_BITS and ADDR_BITS defaults.
- No sub-module is needed: a single FSM plus output registers.

Test Plan:
- Load, zero wait: rs=8'h2A, read enable, REQUEST for 1 cycle, ready=1 in the first valid cycle, data=8'h5C.
  - Expect: valid high for exactly 1 cycle with address 8'h2A, lsu_out=8'h5C, lsu_state=11; after UPDATE, 00.
- Store with back-pressure: rs=8'h10, rt=8'h99, write enable, ready held low for 3 valid cycles.
  - Expect: valid high for 4 cycles with address/data stable at 8'h10/8'h99, then DONE; lsu_out unchanged.
- Both decoded enables set with rs=8'h07.
  - Expect: only mem_read_valid asserts; mem_write_valid stays 0; lsu_error=1 and remains 1 through two more normal loads.
- Disabled thread: enable=0, REQUEST with read enable.
  - Expect: no valid asserted; state stays 00. Then drop enable mid-WAIT of an active load: the load still completes.
- Reset mid-read: assert reset low asynchronously between edges while mem_read_valid=1.
  - Expect: valid, lsu_state and lsu_out go to 0 before the next edge, and remain 0 until the first REQUEST after release.
- Stray ready: mem_write_ready=1 during a pending read, and mem_read_ready=1 while IDLE.
  - Expect: no state change and lsu_out unchanged.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared GPU types: core and LSU state encodings, default datapath widths.
package gpu_pkg;

   localparam int GPU_DATA_BITS = 8;
   localparam int GPU_ADDR_BITS = 8;

   typedef enum logic [2:0] {
      CORE_IDLE    = 3'b000,
      CORE_FETCH   = 3'b001,
      CORE_DECODE  = 3'b010,
      CORE_REQUEST = 3'b011,
      CORE_WAIT    = 3'b100,
      CORE_EXECUTE = 3'b101,
      CORE_UPDATE  = 3'b110,
      CORE_DONE    = 3'b111
   } core_state_t;

   // 2'b10 is reserved and never produced.
   typedef enum logic [1:0] {
      LSU_IDLE       = 2'b00,
      LSU_REQUESTING = 2'b01,
      LSU_DONE       = 2'b11
   } lsu_state_t;

endpackage

// File: rtl/lsu_port.sv
// Per-thread load/store unit: latches rs/rt at REQUEST, runs one valid/ready
// transaction on its memory port and holds the loaded byte until UPDATE.
import gpu_pkg::*;

module lsu_port #(
   parameter int DATA_BITS = GPU_DATA_BITS,
   parameter int ADDR_BITS = GPU_ADDR_BITS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [2:0]           core_state,
   input  logic                 decoded_mem_read_enable,
   input  logic                 decoded_mem_write_enable,
   input  logic [7:0]           rs,
   input  logic [DATA_BITS-1:0] rt,
   output logic                 mem_read_valid,
   output logic [ADDR_BITS-1:0] mem_read_address,
   input  logic                 mem_read_ready,
   input  logic [DATA_BITS-1:0] mem_read_data,
   output logic                 mem_write_valid,
   output logic [ADDR_BITS-1:0] mem_write_address,
   output logic [DATA_BITS-1:0] mem_write_data,
   input  logic                 mem_write_ready,
   output logic [1:0]           lsu_state,
   output logic [DATA_BITS-1:0] lsu_out,
   output logic                 lsu_error
);

   lsu_state_t           state_q, state_d;
   logic                 rd_valid_q, rd_valid_d;
   logic                 wr_valid_q, wr_valid_d;
   logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
   logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_BITS-1:0] wr_data_q, wr_data_d;
   logic [DATA_BITS-1:0] out_q, out_d;
   logic                 err_q, err_d;
   logic                 start;

   assign start = enable && (core_state == CORE_REQUEST) &&
                  (decoded_mem_read_enable || decoded_mem_write_enable);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= LSU_IDLE;
         rd_valid_q <= 1'b0;
         wr_valid_q <= 1'b0;
         rd_addr_q  <= '0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         out_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_valid_q <= rd_valid_d;
         wr_valid_q <= wr_valid_d;
         rd_addr_q  <= rd_addr_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         out_q      <= out_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      rd_valid_d = rd_valid_q;
      wr_valid_d = wr_valid_q;
      rd_addr_d  = rd_addr_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      out_d      = out_q;
      err_d      = err_q;
      case (state_q)
         LSU_IDLE: begin
            if (start) begin
               state_d = LSU_REQUESTING;
               // Read takes priority when both are decoded; the conflict is flagged.
               if (decoded_mem_read_enable) begin
                  rd_valid_d = 1'b1;
                  rd_addr_d  = rs[ADDR_BITS-1:0];
                  if (decoded_mem_write_enable)
                     err_d = 1'b1;
               end else begin
                  wr_valid_d = 1'b1;
                  wr_addr_d  = rs[ADDR_BITS-1:0];
                  wr_data_d  = rt;
               end
            end
         end
         LSU_REQUESTING: begin
            if (rd_valid_q && mem_read_ready) begin
               out_d      = mem_read_data;
               rd_valid_d = 1'b0;
               state_d    = LSU_DONE;
            end else if (wr_valid_q && mem_write_ready) begin
               wr_valid_d = 1'b0;
               state_d    = LSU_DONE;
            end
         end
         LSU_DONE: begin
            if (core_state == CORE_UPDATE)
               state_d = LSU_IDLE;
         end
         default: state_d = LSU_IDLE;
      endcase
   end

   assign mem_read_valid    = rd_valid_q;
   assign mem_read_address  = rd_addr_q;
   assign mem_write_valid   = wr_valid_q;
   assign mem_write_address = wr_addr_q;
   assign mem_write_data    = wr_data_q;
   assign lsu_state         = state_q;
   assign lsu_out           = out_q;
   assign lsu_error         = err_q;

endmodule

// File: tb/tb_lsu_port.sv
// Bench for lsu_port: vector table of transactions with a request scoreboard,
// plus hand-written reset, disabled-thread and stray-ready sequences.
import gpu_pkg::*;

module tb_lsu_port;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [2:0] core_state;
   logic       re, we;
   logic [7:0] rs, rt;
   logic       mem_read_valid, mem_write_valid;
   logic [7:0] mem_read_address, mem_write_address, mem_write_data;
   logic       mem_read_ready, mem_write_ready;
   logic [7:0] mem_read_data;
   logic [1:0] lsu_state;
   logic [7:0] lsu_out;
   logic       lsu_error;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   lsu_port #(.DATA_BITS(8), .ADDR_BITS(8)) dut (
      .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
      .decoded_mem_read_enable(re), .decoded_mem_write_enable(we),
      .rs(rs), .rt(rt),
      .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
      .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
      .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
      .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
      .lsu_state(lsu_state), .lsu_out(lsu_out), .lsu_error(lsu_error)
   );

   typedef struct {
      bit       re;
      bit       we;
      bit       stray;
      int       wait_n;
      logic [7:0] rs;
      logic [7:0] rt;
      logic [7:0] rdata;
      logic [7:0] exp_out;
      bit       exp_err;
   } vec_t;

   typedef struct {
      bit       wr;
      logic [7:0] addr;
      logic [7:0] data;
   } req_t;

   req_t sb[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic do_txn(input vec_t v);
      int   vcycles;
      bit   timeout;
      req_t r;
      @(negedge clk);
      enable = 1'b1; core_state = CORE_REQUEST;
      re = v.re; we = v.we; rs = v.rs; rt = v.rt;
      r.wr = !v.re; r.addr = v.rs; r.data = v.re ? 8'h00 : v.rt;
      sb.push_back(r);
      @(negedge clk);
      // Scramble operands and drop enable: latched values must hold.
      core_state = CORE_WAIT; re = 1'b0; we = 1'b0; enable = 1'b0;
      rs = 8'($urandom); rt = 8'($urandom);
      vcycles = 0; timeout = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (lsu_state == LSU_DONE) begin
            timeout = 1'b0;
            break;
         end
         if (mem_read_valid || mem_write_valid) begin
            vcycles++;
            if (sb.size() == 0) check("sb_empty", 1, 0);
            else if (v.re) begin
               check("rd_addr", mem_read_address, sb[0].addr);
               check("no_wr_valid", mem_write_valid, 0);
            end else begin
               check("wr_addr", mem_write_address, sb[0].addr);
               check("wr_data", mem_write_data, sb[0].data);
               check("no_rd_valid", mem_read_valid, 0);
            end
         end
         if (vcycles > v.wait_n) begin
            mem_read_ready  = v.re;
            mem_write_ready = !v.re;
            mem_read_data   = v.rdata;
            if (sb.size() != 0) void'(sb.pop_front());
         end else begin
            mem_read_ready  = v.stray && !v.re;
            mem_write_ready = v.stray && v.re;
            mem_read_data   = 8'($urandom);
         end
         @(negedge clk);
      end
      mem_read_ready = 1'b0; mem_write_ready = 1'b0;
      check("timeout", timeout, 0);
      check("valid_cycles", vcycles, v.wait_n + 1);
      check("done_state", lsu_state, LSU_DONE);
      check("lsu_out", lsu_out, v.exp_out);
      check("lsu_error", lsu_error, v.exp_err);
      // REQUEST while DONE must not start anything.
      enable = 1'b1; core_state = CORE_REQUEST; re = 1'b1; rs = 8'h77;
      @(negedge clk);
      check("done_hold", lsu_state, LSU_DONE);
      check("done_no_valid", mem_read_valid | mem_write_valid, 0);
      re = 1'b0; core_state = CORE_UPDATE;
      @(negedge clk);
      check("update_idle", lsu_state, LSU_IDLE);
      check("idle_out", lsu_out, v.exp_out);
      core_state = CORE_FETCH;
   endtask

   vec_t vecs[6];
   vec_t last;

   initial begin
      reset = 1'b0; enable = 1'b0; core_state = CORE_IDLE;
      re = 1'b0; we = 1'b0; rs = '0; rt = '0;
      mem_read_ready = 1'b0; mem_write_ready = 1'b0; mem_read_data = '0;

      //            re  we  stray wait  rs     rt     rdata  exp_out exp_err
      vecs[0] = '{1'b1, 1'b0, 1'b0, 0, 8'h2A, 8'h00, 8'h5C, 8'h5C, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 1'b1, 3, 8'h10, 8'h99, 8'hEE, 8'h5C, 1'b0};
      vecs[2] = '{1'b1, 1'b1, 1'b0, 0, 8'h07, 8'hAB, 8'h31, 8'h31, 1'b1};
      vecs[3] = '{1'b1, 1'b0, 1'b1, 1, 8'h40, 8'h00, 8'hA5, 8'hA5, 1'b1};
      vecs[4] = '{1'b1, 1'b0, 1'b0, 2, 8'h41, 8'h00, 8'h3C, 8'h3C, 1'b1};
      vecs[5] = '{1'b0, 1'b1, 1'b0, 0, 8'hFF, 8'h00, 8'h12, 8'h3C, 1'b1};

      #12;
      check("rst_state", lsu_state, LSU_IDLE);
      check("rst_rvalid", mem_read_valid, 0);
      check("rst_wvalid", mem_write_valid, 0);
      check("rst_addr", {mem_read_address, mem_write_address, mem_write_data}, 0);
      check("rst_out", lsu_out, 0);
      check("rst_err", lsu_error, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) do_txn(vecs[i]);

      // Asynchronous reset between edges while a read is pending.
      @(negedge clk);
      enable = 1'b1; core_state = CORE_REQUEST; re = 1'b1; rs = 8'h55;
      @(negedge clk);
      core_state = CORE_WAIT; re = 1'b0;
      check("pre_rst_valid", mem_read_valid, 1);
      check("pre_rst_addr", mem_read_address, 8'h55);
      #2 reset = 1'b0;
      #1;
      check("arst_valid", mem_read_valid, 0);
      check("arst_state", lsu_state, LSU_IDLE);
      check("arst_out", lsu_out, 0);
      check("arst_err", lsu_error, 0);
      check("arst_addr", mem_read_address, 0);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("post_rst_state", lsu_state, LSU_IDLE);
         check("post_rst_out", lsu_out, 0);
         check("post_rst_valid", mem_read_valid | mem_write_valid, 0);
      end

      // Disabled thread with REQUEST, plus stray read ready while idle.
      enable = 1'b0; core_state = CORE_REQUEST; re = 1'b1; rs = 8'h2A;
      mem_read_ready = 1'b1; mem_read_data = 8'hEE;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("dis_state", lsu_state, LSU_IDLE);
         check("dis_valid", mem_read_valid | mem_write_valid, 0);
         check("dis_out", lsu_out, 0);
      end
      mem_read_ready = 1'b0; re = 1'b0; core_state = CORE_FETCH;

      last = '{1'b1, 1'b0, 1'b0, 0, 8'h2A, 8'h00, 8'h5C, 8'h5C, 1'b0};
      do_txn(last);
      check("sb_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
